// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN layer blocks.
// Holds the handshake FSM state encoding and a word-size-generic ReLU.
package cnn_pkg;

  typedef enum logic {eIDLE, eSEND} state_e;

  // Widest word any layer may hand to relu(); narrower words are zero-extended in.
  localparam int unsigned MAX_WORD_SIZE = 64;
  localparam int unsigned SIGN_POS_W    = $clog2(MAX_WORD_SIZE);

  // Clamp a signed word of word_size bits to zero when negative; otherwise pass it.
  function automatic logic [MAX_WORD_SIZE-1:0] relu(
    input logic [MAX_WORD_SIZE-1:0] word,
    input int unsigned              word_size
  );
    logic [SIGN_POS_W-1:0] sign_pos;
    sign_pos = SIGN_POS_W'(word_size - 1);
    relu     = word;
    if (word[sign_pos]) begin
      relu = '0;
    end
  endfunction

endpackage

// File: rtl/conv_output_serializer.sv
// Buffers one conv-layer output vector and streams it word by word (word 0 first)
// over a valid/yumi handshake, optionally applying ReLU on the way out.
module conv_output_serializer
  import cnn_pkg::*;
#(
  parameter int NUM_WORDS  = 3,
  parameter int WORD_SIZE  = 16,
  parameter bit APPLY_RELU = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 valid_i,
  output logic                                 yumi_o,
  input  logic [NUM_WORDS-1:0][WORD_SIZE-1:0] data_i,
  output logic                                 valid_o,
  input  logic                                 yumi_i,
  output logic [WORD_SIZE-1:0]                 data_o,
  output logic                                 first_o,
  output logic                                 last_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_WORDS-1:0][WORD_SIZE-1:0] buf_q, buf_d;

  logic                 at_last;
  logic                 accept;
  logic [WORD_SIZE-1:0] cur_word;
  logic [WORD_SIZE-1:0] out_word;

  assign at_last  = (idx_q == LAST_IDX);
  assign cur_word = buf_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    accept  = 1'b0;
    valid_o = 1'b0;

    case (state_q)
      eIDLE: begin
        accept = valid_i && !reset_i;
        if (accept) begin
          buf_d   = data_i;
          idx_d   = '0;
          state_d = eSEND;
        end
      end
      eSEND: begin
        valid_o = 1'b1;
        if (yumi_i) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            // Reload on the last word's handshake so the next vector follows with no bubble.
            if (valid_i && !reset_i) begin
              accept = 1'b1;
              buf_d  = data_i;
            end else begin
              state_d = eIDLE;
            end
          end
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  assign yumi_o = accept;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  if (APPLY_RELU) begin : g_relu
    assign out_word = WORD_SIZE'(relu(MAX_WORD_SIZE'(cur_word), 32'(WORD_SIZE)));
  end else begin : g_pass
    assign out_word = cur_word;
  end

  assign data_o  = valid_o ? out_word : '0;
  assign first_o = valid_o && (idx_q == '0);
  assign last_o  = valid_o && at_last;

endmodule

// File: tb/tb_conv_output_serializer.sv
// Scoreboard bench: three serializer configurations, each with its own producer,
// consumer and monitor, checked against a word-level reference queue.
module tb_conv_output_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [15:0] w;
    logic        f;
    logic        l;
  } exp_t;

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s inst%0d: got %h want %h at %0t", nm, inst, got, want, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int NW = (gi == 2) ? 1 : 3;
    localparam bit RL = (gi == 1) ? 1'b0 : 1'b1;

    logic             valid_i, yumi_o, valid_o, yumi_i, first_o, last_o;
    logic [15:0]      data_o;
    logic [2:0][15:0] vec;
    int               cons_mode;   // 0 always ready, 1 random, 2 stalled
    int               pushed_now;
    bit               ready = 1'b0;
    bit               done  = 1'b0;
    exp_t             q[$];

    conv_output_serializer #(
      .NUM_WORDS (NW),
      .WORD_SIZE (16),
      .APPLY_RELU(RL)
    ) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .valid_i(valid_i),
      .yumi_o (yumi_o),
      .data_i (vec[NW-1:0]),
      .valid_o(valid_o),
      .yumi_i (yumi_i),
      .data_o (data_o),
      .first_o(first_o),
      .last_o (last_o)
    );

    function automatic logic [15:0] model(input logic [15:0] w);
      if (RL && $signed(w) < 0) return 16'h0000;
      return w;
    endfunction

    function automatic logic [2:0][15:0] rand_vec();
      logic [2:0][15:0] r;
      r = {16'($urandom), 16'($urandom), 16'($urandom)};
      return r;
    endfunction

    task automatic send(input logic [2:0][15:0] v);
      int guard;
      guard = 0;
      @(negedge clk);
      vec     = v;
      valid_i = 1'b1;
      #1;
      while (!yumi_o && guard < 300) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (!yumi_o) begin
        chk("accept_timeout", gi, 32'(yumi_o), 32'd1);
      end else begin
        for (int w = 0; w < NW; w++) begin
          q.push_back('{w: model(v[w]), f: (w == 0), l: (w == NW - 1)});
        end
        pushed_now = NW;
      end
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(negedge clk);
        valid_i = 1'b0;
        vec     = rand_vec();
      end
    endtask

    task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (q.size() > 0) chk("drain_timeout", gi, 32'(q.size()), 32'd0);
    endtask

    initial begin
      yumi_i = 1'b0;
      forever begin
        @(negedge clk);
        case (cons_mode)
          0:       yumi_i = 1'b1;
          1:       yumi_i = ($urandom_range(0, 9) < 7);
          default: yumi_i = 1'b0;
        endcase
      end
    end

    initial begin
      int   outstanding;
      exp_t e;
      forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
          outstanding = q.size() - pushed_now;
          pushed_now  = 0;
          chk("valid_o", gi, 32'(valid_o), 32'(outstanding > 0));
          if (yumi_o) chk("yumi_o_needs_valid_i", gi, 32'(valid_i), 32'd1);
          if (valid_o && q.size() > 0) begin
            e = q[0];
            chk("data_o", gi, 32'(data_o), 32'(e.w));
            chk("first_o", gi, 32'(first_o), 32'(e.f));
            chk("last_o", gi, 32'(last_o), 32'(e.l));
            if (yumi_i) void'(q.pop_front());
          end else if (!valid_o) begin
            chk("idle_outputs", gi, 32'({data_o, first_o, last_o}), 32'd0);
          end
        end
      end
    end

    initial begin
      logic [2:0][15:0] v;
      valid_i    = 1'b0;
      vec        = '0;
      cons_mode  = 0;
      pushed_now = 0;
      @(negedge rst);

      v = {16'h0300, 16'hFF00, 16'h0100};
      send(v);
      idle(4);
      v = {16'h7FFF, 16'h0001, 16'h8001};
      send(v);
      idle(3);

      // Stall the consumer while the producer already offers the next vector.
      v = {16'h0300, 16'hFF00, 16'h0100};
      send(v);
      cons_mode = 2;
      fork
        begin
          repeat (6) @(negedge clk);
          #1 cons_mode = 0;
        end
      join_none
      send(rand_vec());
      idle(2);
      drain();

      v = {16'd3, 16'd2, 16'd1};
      send(v);
      v = {16'd6, 16'd5, 16'd4};
      send(v);
      idle(1);
      drain();

      cons_mode = 1;
      repeat (30) begin
        send(rand_vec());
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(1);
      #1 cons_mode = 0;
      drain();

      // Mid-stream reset: park a vector in the buffer, offer another, then reset.
      cons_mode = 2;
      send(rand_vec());
      idle(2);
      @(negedge clk);
      valid_i = 1'b1;
      vec     = rand_vec();
      ready   = 1'b1;
      @(posedge rst);
      #1;
      chk("rst_valid_o", gi, 32'(valid_o), 32'd0);
      chk("rst_yumi_o", gi, 32'(yumi_o), 32'd0);
      chk("rst_data_o", gi, 32'(data_o), 32'd0);
      chk("rst_first_last", gi, 32'({first_o, last_o}), 32'd0);
      q.delete();
      pushed_now = 0;
      @(negedge clk);
      valid_i = 1'b0;
      @(negedge rst);
      cons_mode = 0;
      idle(3);
      chk("post_rst_valid_o", gi, 32'(valid_o), 32'd0);
      v = {16'h0300, 16'hFF00, 16'h0100};
      send(v);
      idle(1);
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    guard = 0;
    while (!(g[0].ready && g[1].ready && g[2].ready) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!(g[0].ready && g[1].ready && g[2].ready)) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got not-ready want ready at %0t", $time);
    end

    @(negedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    guard = 0;
    while (!(g[0].done && g[1].done && g[2].done) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!(g[0].done && g[1].done && g[2].done)) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got not-done want done at %0t", $time);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
